// File: rtl/cpu_pkg.sv
// Shared control-word layout, PC-select encodings and sequencer states for the
// front-end fetch/sequencing stage and the decoders that feed it.
package cpu_pkg;

    localparam int CW_W      = 29;
    localparam int PSEL_HI   = 28;
    localparam int PSEL_LO   = 27;
    localparam int DA_HI     = 26;
    localparam int DA_LO     = 22;
    localparam int SA_HI     = 21;
    localparam int SA_LO     = 17;
    localparam int SB_HI     = 16;
    localparam int SB_LO     = 12;
    localparam int FSEL_HI   = 11;
    localparam int FSEL_LO   = 7;
    localparam int REGW_BIT  = 6;
    localparam int RAMW_BIT  = 5;
    localparam int DSEL_HI   = 4;
    localparam int DSEL_LO   = 3;
    localparam int BSEL_BIT  = 2;
    localparam int PCSEL_BIT = 1;
    localparam int SL_BIT    = 0;

    localparam logic [1:0] PSEL_HOLD = 2'b00;
    localparam logic [1:0] PSEL_INC  = 2'b01;
    localparam logic [1:0] PSEL_LOAD = 2'b10;
    localparam logic [1:0] PSEL_REL  = 2'b11;

    typedef enum logic [1:0] {
        SEQ_FETCH = 2'b00,
        SEQ_EXEC  = 2'b01,
        SEQ_FAULT = 2'b10
    } seq_e;

    function automatic logic [1:0] cw_psel(input logic [CW_W-1:0] cw);
        return cw[PSEL_HI:PSEL_LO];
    endfunction

    function automatic logic cw_pcsel(input logic [CW_W-1:0] cw);
        return cw[PCSEL_BIT];
    endfunction

endpackage

// File: rtl/fetch_sequencer_pc_next.sv
// Combinational next-PC: hold, +4, absolute load, or word-relative branch.
// All arithmetic wraps mod 2^64.
module pc_next
    import cpu_pkg::*;
(
    input  logic [63:0] pc_i,
    input  logic [1:0]  psel_i,
    input  logic        pcsel_i,
    input  logic [63:0] a_bus_i,
    input  logic [63:0] k_i,
    output logic [63:0] pc_o
);

    logic [63:0] operand;

    always_comb begin
        operand = pcsel_i ? a_bus_i : k_i;
        pc_o    = pc_i;
        case (psel_i)
            PSEL_HOLD: pc_o = pc_i;
            PSEL_INC:  pc_o = pc_i + 64'd4;
            PSEL_LOAD: pc_o = operand;
            PSEL_REL:  pc_o = pc_i + {operand[61:0], 2'b00};
            default:   pc_o = pc_i;
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Front-end sequencer: owns PC, IR and micro-state, fetches over req/ack and
// steps multi-cycle instructions using the decoder's controlWord/nextState.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter logic [63:0] RESET_PC      = 64'h0,
    parameter int unsigned FETCH_TIMEOUT = 16,
    parameter int unsigned TMO_W         = 16
) (
    input  logic            clock,
    input  logic            reset,
    output logic            imem_req,
    output logic [63:0]     imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_data,
    output logic [31:0]     instruction,
    output logic [1:0]      state,
    output logic            exec_valid,
    input  logic [CW_W-1:0] controlWord,
    input  logic [1:0]      nextState,
    input  logic [63:0]     K,
    input  logic [63:0]     a_bus,
    input  logic            stall,
    output logic [63:0]     pc,
    output logic            fetch_fault
);

    localparam bit               TMO_EN   = (FETCH_TIMEOUT != 0);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_EN ? FETCH_TIMEOUT - 1 : 0);

    seq_e             seq_q,   seq_d;
    logic [63:0]      pc_q,    pc_d;
    logic [31:0]      ir_q,    ir_d;
    logic [1:0]       state_q, state_d;
    logic [TMO_W-1:0] tmo_q,   tmo_d;

    logic [63:0] pc_upd;
    logic        misaligned;
    logic        cw_unused;

    // Only Psel and PCsel matter here; the rest of the word belongs to the datapath.
    assign cw_unused  = ^{controlWord[DA_HI:BSEL_BIT], controlWord[SL_BIT]};
    assign misaligned = (pc_q[1:0] != 2'b00);

    pc_next u_pc_next (
        .pc_i    (pc_q),
        .psel_i  (cw_psel(controlWord)),
        .pcsel_i (cw_pcsel(controlWord)),
        .a_bus_i (a_bus),
        .k_i     (K),
        .pc_o    (pc_upd)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            seq_q   <= SEQ_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= 32'h0;
            state_q <= 2'b00;
            tmo_q   <= '0;
        end else begin
            seq_q   <= seq_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            state_q <= state_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        seq_d   = seq_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        state_d = state_q;
        tmo_d   = tmo_q;
        case (seq_q)
            SEQ_FETCH: begin
                if (misaligned) begin
                    seq_d = SEQ_FAULT;
                end else if (imem_ack) begin
                    // An ack in the timeout cycle still completes the fetch.
                    ir_d    = imem_data;
                    state_d = 2'b00;
                    tmo_d   = '0;
                    seq_d   = SEQ_EXEC;
                end else if (TMO_EN && (tmo_q == TMO_LAST)) begin
                    seq_d = SEQ_FAULT;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            SEQ_EXEC: begin
                if (!stall) begin
                    pc_d = pc_upd;
                    if (nextState != 2'b00) begin
                        state_d = nextState;
                    end else begin
                        tmo_d = '0;
                        seq_d = SEQ_FETCH;
                    end
                end
            end
            SEQ_FAULT: seq_d = SEQ_FAULT;
            default:   seq_d = SEQ_FAULT;
        endcase
    end

    // Request is gated by reset so the memory sees it drop in the reset cycle.
    assign imem_req    = !reset && (seq_q == SEQ_FETCH) && !misaligned;
    assign imem_addr   = pc_q;
    assign exec_valid  = !reset && (seq_q == SEQ_EXEC);
    assign fetch_fault = !reset && (seq_q == SEQ_FAULT);
    assign instruction = ir_q;
    assign state       = state_q;
    assign pc          = pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed scenarios plus random traffic against a behavioural model of the
// fetch/exec/fault sequencing.
module tb_fetch_sequencer;

    localparam logic [63:0] RPC = 64'h100;
    localparam int          TMO = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [31:0] instruction;
    logic [1:0]  state;
    logic        exec_valid;
    logic [28:0] controlWord;
    logic [1:0]  nextState;
    logic [63:0] K;
    logic [63:0] a_bus;
    logic        stall;
    logic [63:0] pc;
    logic        fetch_fault;

    int checks = 0;
    int errors = 0;

    fetch_sequencer #(.RESET_PC(RPC), .FETCH_TIMEOUT(TMO), .TMO_W(8)) dut (
        .clock(clock), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data), .instruction(instruction),
        .state(state), .exec_valid(exec_valid), .controlWord(controlWord),
        .nextState(nextState), .K(K), .a_bus(a_bus), .stall(stall), .pc(pc),
        .fetch_fault(fetch_fault)
    );

    always #5 clock = ~clock;

    // Model: mode 0 = waiting for instruction, 1 = executing, 2 = faulted.
    int          m_mode = 0;
    int          m_wait = 0;
    logic [63:0] m_pc   = RPC;
    logic [31:0] m_ir   = 32'h0;
    logic [1:0]  m_st   = 2'b00;

    function automatic logic [63:0] m_next(input logic [63:0] cur, input logic [28:0] cw,
                                           input logic [63:0] a, input logic [63:0] k);
        logic [63:0] src;
        src = cw[1] ? a : k;
        case (cw[28:27])
            2'd1:    return cur + 64'd4;
            2'd2:    return src;
            2'd3:    return cur + src * 64'd4;
            default: return cur;
        endcase
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            m_mode <= 0; m_wait <= 0; m_pc <= RPC; m_ir <= 32'h0; m_st <= 2'b00;
        end else if (m_mode == 0) begin
            if (m_pc % 4 != 0) m_mode <= 2;
            else if (imem_ack) begin
                m_ir <= imem_data; m_st <= 2'b00; m_mode <= 1; m_wait <= 0;
            end else if (m_wait + 1 >= TMO) m_mode <= 2;
            else m_wait <= m_wait + 1;
        end else if (m_mode == 1 && !stall) begin
            m_pc <= m_next(m_pc, controlWord, a_bus, K);
            if (nextState != 2'b00) m_st <= nextState;
            else begin
                m_mode <= 0; m_wait <= 0;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        check("imem_req", 64'(imem_req), 64'(!reset && m_mode == 0 && m_pc[1:0] == 2'b00));
        check("imem_addr", imem_addr, m_pc);
        check("pc", pc, m_pc);
        check("instruction", 64'(instruction), 64'(m_ir));
        check("state", 64'(state), 64'(m_st));
        if (!reset) begin
            check("exec_valid", 64'(exec_valid), 64'(m_mode == 1));
            check("fetch_fault", 64'(fetch_fault), 64'(m_mode == 2));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        imem_ack = 1'b0; controlWord = '0; nextState = 2'b00; stall = 1'b0;
        K = '0; a_bus = '0;
    endtask

    task automatic fetch_ack(input logic [31:0] d);
        imem_ack = 1'b1; imem_data = d;
        tick();
        imem_ack = 1'b0;
    endtask

    task automatic exec_cw(input logic [1:0] ps, input logic pcs, input logic [63:0] k,
                           input logic [63:0] a, input logic [1:0] ns, input logic st);
        controlWord = '0; controlWord[28:27] = ps; controlWord[1] = pcs;
        K = k; a_bus = a; nextState = ns; stall = st;
        tick();
        idle();
    endtask

    initial begin
        reset = 1'b1; imem_data = '0; idle();
        tick(); tick();
        @(negedge clock);
        check("lit_rst_req", 64'(imem_req), 64'd0);
        check("lit_rst_pc", pc, 64'h100);
        @(posedge clock); #1; reset = 1'b0;
        @(negedge clock);
        check("lit_fetch_addr", imem_addr, 64'h100);
        check("lit_fetch_req", 64'(imem_req), 64'd1);
        tick(); tick();
        fetch_ack(32'hD61F0000);
        @(negedge clock);
        check("lit_ir", 64'(instruction), 64'hD61F0000);
        check("lit_exec_valid", 64'(exec_valid), 64'd1);

        exec_cw(2'b11, 1'b1, 64'h0, 64'h10, 2'b00, 1'b0);
        @(negedge clock);
        check("lit_br_pc", pc, 64'h140);
        check("lit_br_addr", imem_addr, 64'h140);
        check("lit_br_req", 64'(imem_req), 64'd1);

        fetch_ack(32'h1234_5678);
        @(negedge clock); check("lit_ms_st0", 64'(state), 64'd0);
        exec_cw(2'b00, 1'b0, 64'h0, 64'h0, 2'b01, 1'b0);
        @(negedge clock); check("lit_ms_st1", 64'(state), 64'd1);
        exec_cw(2'b01, 1'b0, 64'h0, 64'h0, 2'b00, 1'b1);
        @(negedge clock);
        check("lit_ms_stall_st", 64'(state), 64'd1);
        check("lit_ms_stall_pc", pc, 64'h140);
        exec_cw(2'b01, 1'b0, 64'h0, 64'h0, 2'b00, 1'b0);
        @(negedge clock); check("lit_ms_pc", pc, 64'h144);
        fetch_ack(32'h0);
        @(negedge clock); check("lit_ms_st_back", 64'(state), 64'd0);

        exec_cw(2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 2'b00, 1'b0);
        fetch_ack(32'h0);
        exec_cw(2'b01, 1'b0, 64'h0, 64'h0, 2'b00, 1'b0);
        @(negedge clock); check("lit_wrap_inc", pc, 64'h0);
        fetch_ack(32'h0);
        exec_cw(2'b11, 1'b0, 64'hC000_0000_0000_0001, 64'h0, 2'b00, 1'b0);
        @(negedge clock); check("lit_wrap_rel", pc, 64'h4);

        fetch_ack(32'h0);
        exec_cw(2'b10, 1'b0, 64'h102, 64'h0, 2'b00, 1'b0);
        @(negedge clock);
        check("lit_mis_pc", pc, 64'h102);
        check("lit_mis_req", 64'(imem_req), 64'd0);
        tick();
        @(negedge clock);
        check("lit_mis_fault", 64'(fetch_fault), 64'd1);
        check("lit_mis_req2", 64'(imem_req), 64'd0);

        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check("lit_tmo_req", 64'(imem_req), 64'd1);
            tick();
        end
        @(negedge clock);
        check("lit_tmo_fault", 64'(fetch_fault), 64'd1);
        check("lit_tmo_req_off", 64'(imem_req), 64'd0);
        fetch_ack(32'hAAAA_5555);
        @(negedge clock);
        check("lit_late_ack_fault", 64'(fetch_fault), 64'd1);
        check("lit_late_ack_exec", 64'(exec_valid), 64'd0);
        reset = 1'b1; tick(); reset = 1'b0;
        @(negedge clock);
        check("lit_rst2_pc", pc, 64'h100);
        check("lit_rst2_fault", 64'(fetch_fault), 64'd0);
        tick(); tick(); tick();
        fetch_ack(32'h5);
        @(negedge clock);
        check("lit_ack_wins", 64'(exec_valid), 64'd1);

        repeat (3000) begin
            reset       = (m_mode == 2 && $urandom_range(0, 2) == 0) || ($urandom_range(0, 299) == 0);
            imem_ack    = 1'($urandom_range(0, 1));
            imem_data   = $urandom;
            controlWord = 29'($urandom);
            nextState   = 2'($urandom_range(0, 3));
            stall       = ($urandom_range(0, 3) == 0);
            K           = {$urandom, $urandom};
            a_bus       = {$urandom, $urandom};
            if ($urandom_range(0, 19) != 0) begin
                K[1:0] = 2'b00; a_bus[1:0] = 2'b00;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
